lockstep_seq: RTL and testbench

Sequencer that moves the cluster cores into and out of lockstep mode safely. It accepts a mode-change request from the lockstep control register, waits for every core to reach the synchronisation barrier, then halts all cores and flips the lockstep mode. It resumes the cores afterwards and handles comparator mismatches by forcing an exit. It sits between the lockstep control register, the event/barrier unit, the per-core halt interface and the lockstep comparator.

---
 rtl/lockstep_pkg.sv | 16 +
 rtl/lockstep_sync_timer.sv | 26 ++
 rtl/lockstep_seq.sv | 110 +++++++++++
 tb/tb_lockstep_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and constants for the lockstep sequencer.
package lockstep_pkg;

    localparam logic [31:0] LOCKSTEP_ADDRESS = 32'h10202400;
    localparam int unsigned MISMATCH_CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HALT,
        ST_SWITCH,
        ST_RESUME,
        ST_LOCKED
    } ls_state_e;

endpackage

// File: rtl/lockstep_sync_timer.sv
// Barrier wait timer: cleared on entry to the wait, counts every waiting cycle,
// flags the last permitted cycle.
module lockstep_sync_timer #(
    parameter int unsigned SYNC_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(SYNC_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(SYNC_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     cnt_q <= '0;
        else if (clear)  cnt_q <= '0;
        else if (en)     cnt_q <= cnt_q + 1'b1;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/lockstep_seq.sv
// Lockstep mode sequencer: barrier sync, halt, mode flip, resume; forced exit on
// comparator mismatch.
module lockstep_seq
    import lockstep_pkg::*;
#(
    parameter int unsigned NB_CORES     = 8,
    parameter int unsigned SYNC_TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_valid_i,
    input  logic                      cfg_enable_i,
    output logic                      cfg_ready_o,
    input  logic [NB_CORES-1:0]       barrier_matched_i,
    output logic [NB_CORES-1:0]       halt_req_o,
    input  logic [NB_CORES-1:0]       halt_ack_i,
    input  logic                      mismatch_i,
    input  logic                      err_clear_i,
    output logic                      lockstep_mode_o,
    output logic                      busy_o,
    output logic                      err_timeout_o,
    output logic                      err_mismatch_o,
    output logic [MISMATCH_CNT_W-1:0] mismatch_cnt_o
);

    ls_state_e                 state_q;
    logic                      target_q;
    logic                      mode_q;
    logic                      err_to_q;
    logic                      err_mm_q;
    logic [MISMATCH_CNT_W-1:0] mm_cnt_q;

    logic barrier_all, ack_all, ack_none;
    logic mm_event, enter_sync, sync_expired, sync_timeout;

    assign barrier_all = &barrier_matched_i;
    assign ack_all     = &halt_ack_i;
    assign ack_none    = ~|halt_ack_i;
    assign mm_event    = (state_q == ST_LOCKED) && mismatch_i;
    // Mismatch pre-empts an exit request, so it must not restart the timer path.
    assign enter_sync  = ((state_q == ST_IDLE) && cfg_valid_i && cfg_enable_i) ||
                         ((state_q == ST_LOCKED) && !mismatch_i && cfg_valid_i && !cfg_enable_i);
    assign sync_timeout = (state_q == ST_SYNC) && !barrier_all && sync_expired;

    lockstep_sync_timer #(.SYNC_TIMEOUT(SYNC_TIMEOUT)) u_sync_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (enter_sync),
        .en      (state_q == ST_SYNC),
        .expired (sync_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            target_q <= 1'b0;
            mode_q   <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            if (err_clear_i)       err_to_q <= 1'b0;
            else if (sync_timeout) err_to_q <= 1'b1;

            case (state_q)
                ST_IDLE: if (cfg_valid_i && cfg_enable_i) begin
                    target_q <= 1'b1;
                    state_q  <= ST_SYNC;
                end
                ST_LOCKED: if (mismatch_i) begin
                    target_q <= 1'b0;
                    state_q  <= ST_HALT;
                end else if (cfg_valid_i && !cfg_enable_i) begin
                    target_q <= 1'b0;
                    state_q  <= ST_SYNC;
                end
                ST_SYNC: if (barrier_all) state_q <= ST_HALT;
                         else if (sync_expired) state_q <= target_q ? ST_IDLE : ST_LOCKED;
                ST_HALT: if (ack_all) state_q <= ST_SWITCH;
                ST_SWITCH: begin
                    mode_q  <= target_q;
                    state_q <= ST_RESUME;
                end
                ST_RESUME: if (ack_none) state_q <= target_q ? ST_LOCKED : ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_mm_q <= 1'b0;
            mm_cnt_q <= '0;
        end else if (err_clear_i) begin
            err_mm_q <= 1'b0;
            mm_cnt_q <= '0;
        end else if (mm_event) begin
            err_mm_q <= 1'b1;
            if (mm_cnt_q != '1) mm_cnt_q <= mm_cnt_q + 1'b1;
        end
    end

    // Cores stay halted through SWITCH so the mode flips while nothing executes.
    assign halt_req_o      = {NB_CORES{(state_q == ST_HALT) || (state_q == ST_SWITCH)}};
    assign cfg_ready_o     = (state_q == ST_IDLE) || (state_q == ST_LOCKED);
    assign busy_o          = !cfg_ready_o;
    assign lockstep_mode_o = mode_q;
    assign err_timeout_o   = err_to_q;
    assign err_mismatch_o  = err_mm_q;
    assign mismatch_cnt_o  = mm_cnt_q;

endmodule

// File: tb/tb_lockstep_seq.sv
// Scoreboard bench for lockstep_seq: expected end-of-transition state queued at
// request time, popped when the sequencer settles back to ready.
module tb_lockstep_seq;

    localparam int NB = 8;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cfg_valid_i = 1'b0, cfg_enable_i = 1'b0, cfg_ready_o;
    logic [NB-1:0] barrier_matched_i = '1, halt_req_o, halt_ack_i, man_ack = '0;
    logic          auto_ack = 1'b1;
    logic          mismatch_i = 1'b0, err_clear_i = 1'b0;
    logic          lockstep_mode_o, busy_o, err_timeout_o, err_mismatch_o;
    logic [7:0]    mismatch_cnt_o;

    lockstep_seq #(.NB_CORES(NB), .SYNC_TIMEOUT(TO)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .cfg_valid_i       (cfg_valid_i),
        .cfg_enable_i      (cfg_enable_i),
        .cfg_ready_o       (cfg_ready_o),
        .barrier_matched_i (barrier_matched_i),
        .halt_req_o        (halt_req_o),
        .halt_ack_i        (halt_ack_i),
        .mismatch_i        (mismatch_i),
        .err_clear_i       (err_clear_i),
        .lockstep_mode_o   (lockstep_mode_o),
        .busy_o            (busy_o),
        .err_timeout_o     (err_timeout_o),
        .err_mismatch_o    (err_mismatch_o),
        .mismatch_cnt_o    (mismatch_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    assign halt_ack_i = auto_ack ? halt_req_o : man_ack;

    typedef struct packed {
        logic       mode;
        logic       et;
        logic       em;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0, n_err = 0;
    logic       m_et = 1'b0, m_em = 1'b0;
    logic [7:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic mode);
        exp_t e;
        e.mode = mode; e.et = m_et; e.em = m_em; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic pulse_req(input logic en);
        cfg_valid_i = 1'b1; cfg_enable_i = en;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag, output int n);
        exp_t e;
        n = 0;
        while (!(cfg_ready_o && !busy_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_settle"}, 32'(n < 200), 1);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
        else begin
            e = exp_q.pop_front();
            chk({tag, "_mode"}, lockstep_mode_o, e.mode);
            chk({tag, "_et"},   err_timeout_o,   e.et);
            chk({tag, "_em"},   err_mismatch_o,  e.em);
            chk({tag, "_cnt"},  mismatch_cnt_o,  e.cnt);
        end
    endtask

    task automatic enter(input string tag);
        int n;
        push_exp(1'b1);
        pulse_req(1'b1);
        drain(tag, n);
    endtask

    task automatic exit_req(input string tag);
        int n;
        push_exp(1'b0);
        pulse_req(1'b0);
        drain(tag, n);
    endtask

    // Drives a mismatch in LOCKED; the model applies clear-over-increment priority.
    task automatic force_exit(input string tag, input logic with_req, input logic clr);
        int n;
        if (clr) begin
            m_cnt = '0; m_em = 1'b0; m_et = 1'b0;
        end else begin
            m_em = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        push_exp(1'b0);
        mismatch_i = 1'b1; err_clear_i = clr;
        cfg_valid_i = with_req; cfg_enable_i = 1'b0;
        @(negedge clk_i);
        mismatch_i = 1'b0; err_clear_i = 1'b0; cfg_valid_i = 1'b0;
        chk({tag, "_c1_halt"}, halt_req_o, 8'hFF);
        chk({tag, "_c1_em"},   err_mismatch_o, m_em);
        chk({tag, "_c1_cnt"},  mismatch_cnt_o, m_cnt);
        drain(tag, n);
        chk({tag, "_lat"}, n, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", cfg_ready_o, 1);
        chk("rst_busy",  busy_o, 0);
        chk("rst_mode",  lockstep_mode_o, 0);
        chk("rst_halt",  halt_req_o, 0);
        chk("rst_et",    err_timeout_o, 0);
        chk("rst_em",    err_mismatch_o, 0);
        chk("rst_cnt",   mismatch_cnt_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Minimum-latency enter, cycle by cycle.
        push_exp(1'b1);
        pulse_req(1'b1);
        chk("en_c1_busy",  busy_o, 1);
        chk("en_c1_ready", cfg_ready_o, 0);
        chk("en_c1_halt",  halt_req_o, 0);
        @(negedge clk_i);
        chk("en_c2_halt",  halt_req_o, 8'hFF);
        chk("en_c2_mode",  lockstep_mode_o, 0);
        @(negedge clk_i);
        chk("en_c3_mode",  lockstep_mode_o, 0);
        @(negedge clk_i);
        chk("en_c4_mode",  lockstep_mode_o, 1);
        chk("en_c4_halt",  halt_req_o, 0);
        chk("en_c4_busy",  busy_o, 1);
        @(negedge clk_i);
        chk("en_c5_ready", cfg_ready_o, 1);
        drain("enter", n);
        chk("enter_lat", n, 0);

        // No-op request in LOCKED.
        push_exp(1'b1);
        pulse_req(1'b1);
        chk("noop_busy", busy_o, 0);
        drain("noop", n);

        exit_req("exit");

        // Timeout: barrier never complete.
        barrier_matched_i = 8'h7F;
        m_et = 1'b1;
        push_exp(1'b0);
        pulse_req(1'b1);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        chk("to_sync_cycles", n, TO);
        drain("timeout", n);
        err_clear_i = 1'b1;
        @(negedge clk_i);
        err_clear_i = 1'b0;
        m_et = 1'b0;
        chk("to_clear", err_timeout_o, 0);

        // Barrier completes on the final counted cycle: match wins.
        push_exp(1'b1);
        pulse_req(1'b1);
        repeat (TO - 1) @(negedge clk_i);
        barrier_matched_i = '1;
        drain("to_edge", n);
        exit_req("to_edge_exit");

        // Mismatch together with exit request.
        enter("mm_enter");
        force_exit("mm_req", 1'b1, 1'b0);

        // Slow halt ack; an exit request mid-transition is dropped.
        auto_ack = 1'b0; man_ack = '0;
        push_exp(1'b1);
        pulse_req(1'b1);
        @(negedge clk_i);
        chk("slow_c2_halt", halt_req_o, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            cfg_valid_i = (i == 3); cfg_enable_i = 1'b0;
            @(negedge clk_i);
            chk("slow_hold_halt", halt_req_o, 8'hFF);
            chk("slow_hold_mode", lockstep_mode_o, 0);
        end
        cfg_valid_i = 1'b0;
        man_ack = '1;
        @(negedge clk_i);
        chk("slow_switch_mode", lockstep_mode_o, 0);
        auto_ack = 1'b1;
        drain("slow", n);
        exit_req("slow_exit");

        // Counter saturation over 300 forced exits.
        for (int i = 0; i < 300; i++) begin
            enter("sat_enter");
            force_exit("sat", 1'b0, 1'b0);
        end
        chk("sat_cnt", mismatch_cnt_o, 8'hFF);

        enter("clr_enter");
        force_exit("clr_mm", 1'b0, 1'b1);

        // Asynchronous reset while halting during an exit.
        enter("rst_enter");
        auto_ack = 1'b0; man_ack = '0;
        pulse_req(1'b0);
        @(negedge clk_i);
        chk("rsth_halt", halt_req_o, 8'hFF);
        chk("rsth_mode", lockstep_mode_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rsta_halt", halt_req_o, 0);
        chk("rsta_mode", lockstep_mode_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; auto_ack = 1'b1;
        m_cnt = '0; m_em = 1'b0; m_et = 1'b0;
        @(negedge clk_i);
        chk("rstr_ready", cfg_ready_o, 1);
        chk("rstr_busy",  busy_o, 0);
        chk("rstr_mode",  lockstep_mode_o, 0);
        enter("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
